// File: rtl/iter_mult_unit.sv
// Iterative shift-add multiplier with start/busy/done handshake and abort.
// One partial-product step per cycle; optional two's-complement via sign-magnitude.
module iter_mult_unit #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    acc_hi;
  logic [WIDTH-1:0]    mult;
  logic [CNT_W-1:0]    cnt;
  logic                neg;

  logic [WIDTH-1:0]    abs_a, abs_b;
  logic                neg_in;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  raw;

  // Signed operands are reduced to magnitudes; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    abs_a  = op_a;
    abs_b  = op_b;
    neg_in = 1'b0;
    if (SIGNED != 0) begin
      if (op_a[WIDTH-1]) abs_a = ~op_a + 1'b1;
      if (op_b[WIDTH-1]) abs_b = ~op_b + 1'b1;
      neg_in = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end
  end

  always_comb begin
    sum = {1'b0, acc_hi};
    if (mult[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
    raw = {acc_hi, mult};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC: begin
        if (abort)                               state_d = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))       state_d = FIX;
      end
      FIX:     state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      mult    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= abs_a;
            mult   <= abs_b;
            acc_hi <= '0;
            cnt    <= '0;
            neg    <= neg_in;
          end
        end
        CALC: begin
          if (!abort) begin
            acc_hi <= sum[WIDTH:1];
            mult   <= {sum[0], mult[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
          end
        end
        // Abort wins over the result write so a cancelled op leaves product untouched.
        FIX: begin
          if (!abort) product <= neg ? (~raw + 1'b1) : raw;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == CALC) || (state_q == FIX);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_iter_mult_unit.sv
// Directed bench for iter_mult_unit: unsigned and signed instances share stimulus.
module tb_iter_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  op_a;
  logic [7:0]  op_b;

  logic        u_busy, u_done, s_busy, s_done;
  logic [15:0] u_product, s_product;
  logic [2:0]  u_state, s_state;

  int tests  = 0;
  int failed = 0;

  iter_mult_unit #(.WIDTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b),
    .busy(u_busy), .done(u_done), .product(u_product), .state(u_state)
  );

  iter_mult_unit #(.WIDTH(8), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b),
    .busy(s_busy), .done(s_done), .product(s_product), .state(s_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and reports edges-to-done and busy cycles seen.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                output int lat, output int busy_cycles);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cycles = u_busy ? 1 : 0;
    while (!u_done && lat < 50) begin
      tick();
      lat++;
      if (u_busy) busy_cycles++;
    end
  endtask

  initial begin
    int lat, bc, dones;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    check_output("reset_state",   32'(u_state),   32'd0);
    check_output("reset_busy",    32'(u_busy),    32'd0);
    check_output("reset_done",    32'(u_done),    32'd0);
    check_output("reset_product", 32'(u_product), 32'd0);
    rst = 1'b0;
    tick();

    apply_stimulus(8'd200, 8'd150, lat, bc);
    check_output("u200x150_latency", 32'(lat), 32'd9);
    check_output("u200x150_busy",    32'(bc),  32'd9);
    check_output("u200x150_product", 32'(u_product), 32'h7530);
    check_output("s200x150_product", 32'(s_product), 32'h1730);
    tick();
    check_output("done_single_cycle", 32'(u_done),  32'd0);
    check_output("idle_after_done",   32'(u_state), 32'd0);

    apply_stimulus(8'hFD, 8'h05, lat, bc);
    check_output("sFDx05_product", 32'(s_product), 32'hFFF1);
    check_output("uFDx05_product", 32'(u_product), 32'h04F1);
    tick();

    apply_stimulus(8'h80, 8'h80, lat, bc);
    check_output("s80x80_product", 32'(s_product), 32'h4000);
    check_output("u80x80_product", 32'(u_product), 32'h4000);
    tick();

    apply_stimulus(8'h7F, 8'h80, lat, bc);
    check_output("s7Fx80_product", 32'(s_product), 32'hC080);
    check_output("u7Fx80_product", 32'(u_product), 32'h3F80);
    tick();

    apply_stimulus(8'h00, 8'hFF, lat, bc);
    check_output("zero_latency", 32'(lat),       32'd9);
    check_output("zero_product", 32'(u_product), 32'd0);
    check_output("zero_sproduct", 32'(s_product), 32'd0);
    tick();

    // Start held high with fresh operands while busy must not recapture.
    op_a  = 8'd5;
    op_b  = 8'd7;
    start = 1'b1;
    tick();
    op_a  = 8'd99;
    op_b  = 8'd77;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) start = 1'b0;
      tick();
      if (u_done) dones++;
    end
    check_output("busy_start_product", 32'(u_product), 32'd35);
    check_output("busy_start_dones",   32'(dones),     32'd1);

    apply_stimulus(8'd9, 8'd9, lat, bc);
    check_output("restart_latency", 32'(lat),       32'd9);
    check_output("restart_product", 32'(u_product), 32'd81);
    tick();

    op_a  = 8'd12;
    op_b  = 8'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_state", 32'(u_state), 32'd0);
    check_output("abort_busy",  32'(u_busy),  32'd0);
    dones = u_done ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_done) dones++;
    end
    check_output("abort_no_done",  32'(dones),     32'd0);
    check_output("abort_product",  32'(u_product), 32'd81);
    check_output("abort_sproduct", 32'(s_product), 32'd81);

    op_a  = 8'd3;
    op_b  = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_output("rst_mid_state",   32'(u_state),   32'd0);
    check_output("rst_mid_busy",    32'(u_busy),    32'd0);
    check_output("rst_mid_done",    32'(u_done),    32'd0);
    check_output("rst_mid_product", 32'(u_product), 32'd0);
    start = 1'b1;
    tick();
    check_output("rst_start_state", 32'(u_state), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_output("post_rst_idle", 32'(u_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
